// File: rtl/piano_note_ctrl_if.sv
// Key/speaker bundle for piano_note_ctrl.
// Optional octave_up input exists only when PIANO_OCTAVE_UP_EN is defined.
interface piano_note_ctrl_if #(
    parameter int unsigned NKEYS = 8
);
    logic [NKEYS-1:0] keys;
    logic             speaker;
    logic             note_valid;
    logic [2:0]       note_idx;
`ifdef PIANO_OCTAVE_UP_EN
    logic             octave_up;

    modport master (output keys, output octave_up,
                    input speaker, input note_valid, input note_idx);
    modport slave  (input keys, input octave_up,
                    output speaker, output note_valid, output note_idx);
`else
    modport master (output keys, input speaker, input note_valid, input note_idx);
    modport slave  (input keys, output speaker, output note_valid, output note_idx);
`endif
endinterface

// File: rtl/piano_note_ctrl.sv
// Debounces NKEYS push-buttons and plays the lowest held key on one shared tone divider.
// Define PIANO_OCTAVE_UP_EN to add the octave_up input, which halves the period at note load.
module piano_note_ctrl #(
    parameter int unsigned NKEYS           = 8,
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned CNT_W           = 19
) (
    input logic              clk,
    input logic              rst_n,
    piano_note_ctrl_if.slave bus
);
    localparam int unsigned DB_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StLoad, StPlay} state_e;

    logic [NKEYS-1:0] sync1_q, sk_q, db_q;
    logic [DB_W-1:0]  db_cnt_q [NKEYS];

    state_e           state_q;
    logic [2:0]       cur_q;
    logic [CNT_W-1:0] half_q, tone_q;
    logic             speaker_q, note_valid_q;
    logic [2:0]       note_idx_q;
    logic [2:0]       lowest;
    logic [CNT_W-1:0] load_half;

    function automatic logic [CNT_W-1:0] half_of(input logic [2:0] idx);
        case (idx)
            3'd0:    half_of = CNT_W'(95555);
            3'd1:    half_of = CNT_W'(85130);
            3'd2:    half_of = CNT_W'(75841);
            3'd3:    half_of = CNT_W'(71585);
            3'd4:    half_of = CNT_W'(63775);
            3'd5:    half_of = CNT_W'(56817);
            3'd6:    half_of = CNT_W'(50618);
            default: half_of = CNT_W'(47777);
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sk_q    <= '0;
            db_q    <= '0;
            for (int i = 0; i < int'(NKEYS); i++) db_cnt_q[i] <= '0;
        end else begin
            sync1_q <= bus.keys;
            sk_q    <= sync1_q;
            for (int i = 0; i < int'(NKEYS); i++) begin
                if (sk_q[i] == db_q[i]) begin
                    db_cnt_q[i] <= '0;
                end else if (db_cnt_q[i] == DB_LAST) begin
                    db_q[i]     <= ~db_q[i];
                    db_cnt_q[i] <= '0;
                end else begin
                    db_cnt_q[i] <= db_cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // Highest index scanned first so the lowest set bit wins.
    always_comb begin
        lowest = 3'd0;
        for (int i = int'(NKEYS) - 1; i >= 0; i--) begin
            if (db_q[i]) lowest = 3'(i);
        end
    end

`ifdef PIANO_OCTAVE_UP_EN
    logic oct1_q, oct_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            oct1_q <= 1'b0;
            oct_q  <= 1'b0;
        end else begin
            oct1_q <= bus.octave_up;
            oct_q  <= oct1_q;
        end
    end

    always_comb begin
        load_half = half_of(cur_q);
        if (oct_q) load_half = ((load_half + CNT_W'(1)) >> 1) - CNT_W'(1);
    end
`else
    always_comb begin
        load_half = half_of(cur_q);
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            cur_q        <= 3'd0;
            half_q       <= '0;
            tone_q       <= '0;
            speaker_q    <= 1'b0;
            note_valid_q <= 1'b0;
            note_idx_q   <= 3'd0;
        end else begin
            case (state_q)
                StIdle: begin
                    speaker_q    <= 1'b0;
                    note_valid_q <= 1'b0;
                    tone_q       <= '0;
                    if (|db_q) begin
                        state_q <= StLoad;
                        cur_q   <= lowest;
                    end
                end
                StLoad: begin
                    half_q       <= load_half;
                    tone_q       <= '0;
                    speaker_q    <= 1'b0;
                    note_idx_q   <= cur_q;
                    note_valid_q <= 1'b1;
                    state_q      <= StPlay;
                end
                StPlay: begin
                    // Only a release of the sounding key ends the note; new presses wait.
                    if (!db_q[cur_q]) begin
                        speaker_q    <= 1'b0;
                        note_valid_q <= 1'b0;
                        tone_q       <= '0;
                        if (|db_q) begin
                            state_q <= StLoad;
                            cur_q   <= lowest;
                        end else begin
                            state_q <= StIdle;
                        end
                    end else if (tone_q == half_q) begin
                        tone_q    <= '0;
                        speaker_q <= ~speaker_q;
                    end else begin
                        tone_q <= tone_q + 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.speaker    = speaker_q;
    assign bus.note_valid = note_valid_q;
    assign bus.note_idx   = note_idx_q;
endmodule

// File: tb/tb_piano_note_ctrl.sv
// Directed self-checking bench for piano_note_ctrl with DEBOUNCE_CYCLES=4.
// Edge counts below are relative to the first clock edge that samples a key change.
module tb_piano_note_ctrl;
    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad = 0;

    piano_note_ctrl_if #(.NKEYS(8)) bus ();

    piano_note_ctrl #(
        .NKEYS          (8),
        .DEBOUNCE_CYCLES(4),
        .CNT_W          (19)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        assert (got === want) else begin
            bad++;
            $error("FAIL %s: got %0d want %0d", tag, got, want);
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        bus.keys = 8'hFF;
`ifdef PIANO_OCTAVE_UP_EN
        bus.octave_up = 1'b0;
`endif
        for (int i = 0; i < 3; i++) begin
            step(1);
            check("rst_speaker", bus.speaker, 0);
            check("rst_valid", bus.note_valid, 0);
            check("rst_idx", bus.note_idx, 0);
        end
        bus.keys = 8'h00;
        rst_n    = 1'b1;
        step(3);
        check("idle_valid", bus.note_valid, 0);

        // Key 4: sk after e2, db after e6, LOAD after e7, PLAY after e8.
        bus.keys = 8'h10;
        step(6);
        check("k4_pre_load_valid", bus.note_valid, 0);
        step(1);
        check("k4_load_valid", bus.note_valid, 0);
        step(1);
        check("k4_play_valid", bus.note_valid, 1);
        check("k4_play_idx", bus.note_idx, 4);
        check("k4_play_spk", bus.speaker, 0);
        // First rise H+1 = 63776 edges after PLAY entry.
        step(63775);
        check("k4_before_rise", bus.speaker, 0);
        step(1);
        check("k4_rise", bus.speaker, 1);

        // Release while speaker high: db falls after r6, IDLE after r7.
        bus.keys = 8'h00;
        step(6);
        check("rel_spk_held", bus.speaker, 1);
        check("rel_valid_held", bus.note_valid, 1);
        step(1);
        check("rel_spk_low", bus.speaker, 0);
        check("rel_valid_low", bus.note_valid, 0);
        check("rel_idx_hold", bus.note_idx, 4);

        // Bounce on key 0: 1,0,1 then steady; last rise sampled at e3, db after e8.
        bus.keys = 8'h01;
        step(1);
        bus.keys = 8'h00;
        step(1);
        bus.keys = 8'h01;
        step(1);
        step(5);
        check("bnc_e8_valid", bus.note_valid, 0);
        step(1);
        check("bnc_load_valid", bus.note_valid, 0);
        check("bnc_load_idx", bus.note_idx, 4);
        step(1);
        check("bnc_play_valid", bus.note_valid, 1);
        check("bnc_play_idx", bus.note_idx, 0);

        // Release key 0 and press key 5 together: straight to LOAD, no IDLE.
        bus.keys = 8'h20;
        step(7);
        check("swap_load_valid", bus.note_valid, 0);
        check("swap_load_spk", bus.speaker, 0);
        step(1);
        check("swap_play_valid", bus.note_valid, 1);
        check("swap_play_idx", bus.note_idx, 5);

        // Sticky: key 1 pressed while key 5 sounds.
        bus.keys = 8'h22;
        step(10);
        check("sticky_idx", bus.note_idx, 5);
        check("sticky_valid", bus.note_valid, 1);
        bus.keys = 8'h02;
        step(7);
        check("next_load_valid", bus.note_valid, 0);
        check("next_load_spk", bus.speaker, 0);
        check("next_load_idx", bus.note_idx, 5);
        step(1);
        check("next_play_valid", bus.note_valid, 1);
        check("next_play_idx", bus.note_idx, 1);

        // One-cycle reset during PLAY.
        bus.keys = 8'h00;
        rst_n    = 1'b0;
        step(1);
        check("mid_rst_spk", bus.speaker, 0);
        check("mid_rst_valid", bus.note_valid, 0);
        check("mid_rst_idx", bus.note_idx, 0);
        rst_n = 1'b1;
        step(8);
        check("post_rst_valid", bus.note_valid, 0);

`ifdef PIANO_OCTAVE_UP_EN
        // Octave up on key 7: half 23888, first rise 23889 edges after PLAY entry.
        bus.octave_up = 1'b1;
        step(3);
        bus.keys = 8'h80;
        step(8);
        check("oct_play_valid", bus.note_valid, 1);
        check("oct_play_idx", bus.note_idx, 7);
        bus.octave_up = 1'b0;
        step(23888);
        check("oct_before_rise", bus.speaker, 0);
        step(1);
        check("oct_rise", bus.speaker, 1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
